// File: rtl/sc_pkg.sv
// +----------------------------------------------------------------------------+
// | sc_pkg : shared stochastic-computing types, constants and LFSR step        |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

package sc_pkg;

  localparam int SC_WIDTH = 8;
  localparam logic [SC_WIDTH-1:0] SC_TAPS = 8'hB8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sng_state_t;

  // The zero-detect term splices state 0 into the m-sequence, giving a full 2^W period.
  function automatic logic [SC_WIDTH-1:0] de_bruijn_next(
    input logic [SC_WIDTH-1:0] q,
    input logic [SC_WIDTH-1:0] taps = SC_TAPS
  );
    logic fb;
    fb = (^(q & taps)) ^ (q[SC_WIDTH-2:0] == '0);
    return {q[SC_WIDTH-2:0], fb};
  endfunction

endpackage

`default_nettype wire

// File: rtl/sc_sng_if.sv
// +----------------------------------------------------------------------------+
// | sc_sng_if : operand / bitstream interface of the stochastic generator      |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

interface sc_sng_if import sc_pkg::*; #(
  parameter int WIDTH = SC_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] x;
  logic             seed_ld;
  logic [WIDTH-1:0] seed;
  logic             busy;
  logic             sn;
  logic             sn_valid;
  logic             last;
  logic             done;

  modport master (
    output start, x, seed_ld, seed,
    input  busy, sn, sn_valid, last, done
  );

  modport slave (
    input  start, x, seed_ld, seed,
    output busy, sn, sn_valid, last, done
  );

endinterface

`default_nettype wire

// File: rtl/sc_lfsr.sv
// +----------------------------------------------------------------------------+
// | sc_lfsr : de Bruijn-extended Fibonacci LFSR with load and enable           |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module sc_lfsr import sc_pkg::*; #(
  parameter int               WIDTH = SC_WIDTH,
  parameter logic [WIDTH-1:0] TAPS  = SC_TAPS,
  parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             en,
  input  wire logic             ld,
  input  wire logic [WIDTH-1:0] d,
  output logic      [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_next;

  generate
    if (WIDTH == SC_WIDTH) begin : g_pkg_step
      assign w_next = de_bruijn_next(r_q, TAPS);
    end else begin : g_generic_step
      assign w_next = {r_q[WIDTH-2:0], (^(r_q & TAPS)) ^ (r_q[WIDTH-2:0] == '0)};
    end
  endgenerate

  // Load wins over advance so a seed written in the same cycle is never skipped.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_q <= SEED;
    end else if (ld) begin
      r_q <= d;
    end else if (en) begin
      r_q <= w_next;
    end
  end

  assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/sc_sng.sv
// +----------------------------------------------------------------------------+
// | sc_sng : exact unipolar stochastic number generator (LFSR comparator)      |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module sc_sng import sc_pkg::*; #(
  parameter int               WIDTH = SC_WIDTH,
  parameter logic [WIDTH-1:0] TAPS  = SC_TAPS,
  parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  wire logic clk,
  input  wire logic rst,
  sc_sng_if.slave   bus
);

  localparam logic [WIDTH:0] c_len_last = {1'b0, {WIDTH{1'b1}}};

  sng_state_t       r_state;
  logic [WIDTH-1:0] r_x_q;
  logic [WIDTH:0]   r_len;
  logic             r_busy;
  logic             r_sn;
  logic             r_sn_valid;
  logic             r_last;
  logic             r_done;

  logic [WIDTH-1:0] w_lfsr_q;
  logic             w_lfsr_en;
  logic             w_lfsr_ld;

  assign w_lfsr_en = (r_state == RUN);
  assign w_lfsr_ld = (r_state == IDLE) && bus.seed_ld;

  sc_lfsr #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .SEED  (SEED)
  ) u_lfsr (
    .clk (clk),
    .rst (rst),
    .en  (w_lfsr_en),
    .ld  (w_lfsr_ld),
    .d   (bus.seed),
    .q   (w_lfsr_q)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_x_q      <= '0;
      r_len      <= '0;
      r_busy     <= 1'b0;
      r_sn       <= 1'b0;
      r_sn_valid <= 1'b0;
      r_last     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_busy     <= 1'b0;
      r_sn       <= 1'b0;
      r_sn_valid <= 1'b0;
      r_last     <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_state <= RUN;
            r_x_q   <= bus.x;
            r_len   <= '0;
            r_busy  <= 1'b1;
          end
        end
        RUN: begin
          // Every LFSR state appears once per stream, so exactly x_q of them fall below x_q.
          r_sn       <= (w_lfsr_q < r_x_q);
          r_sn_valid <= 1'b1;
          r_len      <= r_len + 1'b1;
          if (r_len == c_len_last) begin
            r_last  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_busy  <= 1'b1;
          end
        end
        DONE: begin
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.sn       = r_sn;
  assign bus.sn_valid = r_sn_valid;
  assign bus.last     = r_last;
  assign bus.done     = r_done;

endmodule

`default_nettype wire

// File: tb/tb_sc_sng.sv
// +----------------------------------------------------------------------------+
// | tb_sc_sng : self-checking bench for sc_sng (stream-level model)            |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_sc_sng;
  import sc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rst_q;

  always #5 clk = ~clk;

  sc_sng_if #(.WIDTH(SC_WIDTH)) bus ();

  sc_sng #(
    .WIDTH (SC_WIDTH),
    .TAPS  (8'hB8),
    .SEED  (8'h01)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Stream plan published by the driver, consumed by the monitor.
  bit exp_bits [0:255];
  int arm_x    = 0;
  int arm_cnt  = 0;
  bit checking = 1'b0;
  int m_q      = 1;

  // LFSR reference in integer arithmetic: taps at bits 7,5,4,3 plus the all-zero-low splice.
  function automatic int model_next(int q);
    int fb;
    fb = ((q >> 7) ^ (q >> 5) ^ (q >> 4) ^ (q >> 3)) & 1;
    if ((q % 128) == 0) fb = fb ^ 1;
    return ((q * 2) % 256) + fb;
  endfunction

  always @(posedge clk) rst_q <= rst;

  // Monitor: phase p counts cycles after the accepting edge; bits appear at p=1..256.
  int p        = -1;
  int seen_arm = 0;
  int pop      = 0;
  int vcnt     = 0;

  always @(negedge clk) begin
    logic e_busy, e_valid, e_sn, e_last, e_done;
    if (checking) begin
      if (rst_q !== 1'b1) begin
        p = -1; pop = 0; vcnt = 0;
      end else if (arm_cnt != seen_arm) begin
        seen_arm = arm_cnt; p = 0; pop = 0; vcnt = 0;
      end else if (p >= 0) begin
        p++;
      end
      e_busy  = (p >= 0) && (p <= 255);
      e_valid = (p >= 1) && (p <= 256);
      e_sn    = e_valid ? exp_bits[p-1] : 1'b0;
      e_last  = (p == 256);
      e_done  = (p == 257);
      n_vec++;
      if ({bus.busy, bus.sn, bus.sn_valid, bus.last, bus.done} !==
          {e_busy, e_sn, e_valid, e_last, e_done}) begin
        n_bad++;
        $display("FAIL outputs t=%0t p=%0d got busy/sn/valid/last/done=%b%b%b%b%b want %b%b%b%b%b",
                 $time, p, bus.busy, bus.sn, bus.sn_valid, bus.last, bus.done,
                 e_busy, e_sn, e_valid, e_last, e_done);
      end
      if (bus.sn_valid === 1'b1) vcnt++;
      if (bus.sn_valid === 1'b1 && bus.sn === 1'b1) pop++;
      if (p == 257) begin
        n_vec++;
        if (pop != arm_x || vcnt != 256) begin
          n_bad++;
          $display("FAIL stream_count x=%0d got ones=%0d valid=%0d want ones=%0d valid=256",
                   arm_x, pop, vcnt, arm_x);
        end
      end
    end
  end

  task automatic check_val(string name, int got, int want);
    n_vec++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic load_seed(logic [7:0] s);
    bus.seed_ld = 1'b1;
    bus.seed    = s;
    @(posedge clk);
    m_q = int'(s);
    #2;
    bus.seed_ld = 1'b0;
  endtask

  // Starts a stream (optionally loading a seed the same cycle) and runs it to completion.
  // abort_at > 0 pulls reset so that it is sampled right after valid bit abort_at.
  task automatic run_stream(logic [7:0] xv, bit ld, logic [7:0] s, bit disturb, int abort_at);
    bus.start   = 1'b1;
    bus.x       = xv;
    bus.seed_ld = ld;
    bus.seed    = s;
    @(posedge clk);
    if (ld) m_q = int'(s);
    for (int i = 0; i < 256; i++) begin
      exp_bits[i] = (m_q < int'(xv));
      m_q = model_next(m_q);
    end
    arm_x = int'(xv);
    arm_cnt++;
    #2;
    bus.start   = 1'b0;
    bus.seed_ld = 1'b0;
    for (int c = 0; c < 260; c++) begin
      if (disturb && c < 250) begin
        bus.start   = 1'($urandom_range(0, 1));
        bus.seed_ld = 1'($urandom_range(0, 1));
        bus.x       = 8'($urandom);
        bus.seed    = 8'($urandom);
      end else begin
        bus.start   = 1'b0;
        bus.seed_ld = 1'b0;
      end
      if (abort_at > 0 && c == abort_at) rst = 1'b0;
      @(posedge clk);
      if (abort_at > 0 && c == abort_at) begin
        m_q = 1;
        #2;
        rst = 1'b1;
        bus.start   = 1'b0;
        bus.seed_ld = 1'b0;
        repeat (4) step();
        return;
      end
      #2;
    end
  endtask

  logic [7:0] sweep_x    [5] = '{8'd0, 8'd1, 8'd127, 8'd254, 8'd255};
  logic [7:0] sweep_seed [3] = '{8'h00, 8'h5A, 8'hFF};

  initial begin
    bus.start   = 1'b0;
    bus.x       = '0;
    bus.seed_ld = 1'b0;
    bus.seed    = '0;
    rst         = 1'b0;

    // Model pins: 01->02, 08->11, 80->00 (zero splice), 00->01.
    check_val("model_01", model_next(8'h01), 8'h02);
    check_val("model_08", model_next(8'h08), 8'h11);
    check_val("model_80", model_next(8'h80), 8'h00);
    check_val("model_00", model_next(8'h00), 8'h01);

    step();
    checking = 1'b1;
    repeat (2) step();
    check_val("reset_lfsr", int'(dut.u_lfsr.q), 8'h01);
    rst = 1'b1;
    m_q = 1;
    repeat (3) step();

    run_stream(8'd128, 1'b0, 8'h00, 1'b0, 0);

    foreach (sweep_x[i]) begin
      foreach (sweep_seed[j]) begin
        load_seed(sweep_seed[j]);
        step();
        run_stream(sweep_x[i], 1'b0, 8'h00, 1'b0, 0);
      end
    end

    // Simultaneous seed load and start; the chained counter should read 200 at done.
    run_stream(8'd200, 1'b1, 8'h5A, 1'b0, 0);

    run_stream(8'd77, 1'b0, 8'h00, 1'b1, 0);

    run_stream(8'd128, 1'b0, 8'h00, 1'b0, 100);
    check_val("abort_lfsr_seed", int'(dut.u_lfsr.q), 8'h01);
    run_stream(8'd128, 1'b0, 8'h00, 1'b0, 0);

    repeat (3) step();
    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
